data_mem_responder: RTL and testbench

- Multi-cycle, handshaked data-memory responder serving the core's load/store requests.
- The core is the initiator; this block is the memory end of that interface.
- Replaces the single-cycle data memory when the core moves to stall-capable memory access.
- Byte-addressed little-endian storage; byte/half/word accesses encoded as RISC-V funct3; configurable wait states.

---
 rtl/data_mem_responder_if.sv | 26 ++
 rtl/data_mem_responder.sv | 168 ++++++++++++++++
 tb/tb_data_mem_responder.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// Load/store request and response channels between the core (initiator) and
// the data-memory responder.
interface data_mem_responder_if #(
  parameter int unsigned WIDTH = 32
);
  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic [2:0]       req_mode;
  logic [WIDTH-1:0] req_addr;
  logic [WIDTH-1:0] req_wdata;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_rdata;
  logic             rsp_err;

  modport master (
    output req_valid, req_we, req_mode, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_mode, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Multi-cycle data memory answering core load/store requests over a valid/ready
// handshake; byte-addressed little-endian storage with configurable wait states.
module data_mem_responder #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned ADDR_BITS = 17,
  parameter int unsigned LATENCY   = 2
) (
  input logic                 clk,
  input logic                 rst,
  data_mem_responder_if.slave bus
);
  localparam int unsigned Bytes = 2 ** ADDR_BITS;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 we_q;
  logic [2:0]           mode_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic [WIDTH-1:0]     wdata_q;
  logic [WIDTH-1:0]     rdata_q, rdata_d;
  logic                 err_q, err_d;
  logic [7:0]           mem [Bytes];

  logic                 accept;
  logic                 commit;
  logic                 op_we;
  logic [2:0]           op_mode;
  logic [ADDR_BITS-1:0] op_addr;
  logic [WIDTH-1:0]     op_wdata;
  logic                 op_err;
  logic [1:0]           op_size;
  logic [7:0]           rb0, rb1, rb2, rb3;
  logic [WIDTH-1:0]     load_val;
  logic                 unused_addr;

  assign bus.req_ready = (state_q == StIdle) && rst;
  assign bus.rsp_valid = (state_q == StResp);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

  assign accept      = bus.req_valid && bus.req_ready;
  assign commit      = (state_d == StResp) && (state_q != StResp);
  assign unused_addr = ^bus.req_addr[WIDTH-1:ADDR_BITS];

  // In IDLE the operands come straight from the bus so a zero-wait access can
  // commit on its own accept edge; otherwise the latched copy is used.
  always_comb begin
    if (state_q == StIdle) begin
      op_we    = bus.req_we;
      op_mode  = bus.req_mode;
      op_addr  = bus.req_addr[ADDR_BITS-1:0];
      op_wdata = bus.req_wdata;
    end else begin
      op_we    = we_q;
      op_mode  = mode_q;
      op_addr  = addr_q;
      op_wdata = wdata_q;
    end
  end

  always_comb begin
    op_size = 2'd0;
    op_err  = 1'b0;
    case (op_mode)
      3'b000, 3'b100: op_size = 2'd0;
      3'b001, 3'b101: begin
        op_size = 2'd1;
        op_err  = op_addr[0];
      end
      3'b010: begin
        op_size = 2'd2;
        op_err  = |op_addr[1:0];
      end
      default: op_err = 1'b1;
    endcase
    // Unsigned modes have no store counterpart.
    if (op_we && op_mode[2]) op_err = 1'b1;
  end

  assign rb0 = mem[op_addr];
  assign rb1 = mem[op_addr + ADDR_BITS'(1)];
  assign rb2 = mem[op_addr + ADDR_BITS'(2)];
  assign rb3 = mem[op_addr + ADDR_BITS'(3)];

  always_comb begin
    load_val = WIDTH'({rb3, rb2, rb1, rb0});
    case (op_mode)
      3'b000:  load_val = {{(WIDTH-8){rb0[7]}}, rb0};
      3'b001:  load_val = {{(WIDTH-16){rb1[7]}}, rb1, rb0};
      3'b100:  load_val = {{(WIDTH-8){1'b0}}, rb0};
      3'b101:  load_val = {{(WIDTH-16){1'b0}}, rb1, rb0};
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          if (LATENCY == 0) begin
            state_d = StResp;
          end else begin
            state_d = StWait;
            cnt_d   = 4'(LATENCY - 1);
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) state_d = StResp;
        else               cnt_d   = cnt_q - 4'd1;
      end
      StResp: begin
        if (bus.rsp_ready) begin
          state_d = StIdle;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
    if (commit) begin
      rdata_d = (op_we || op_err) ? '0 : load_val;
      err_d   = op_err;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      mode_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (accept) begin
        we_q    <= bus.req_we;
        mode_q  <= bus.req_mode;
        addr_q  <= bus.req_addr[ADDR_BITS-1:0];
        wdata_q <= bus.req_wdata;
      end
    end
  end

  // Storage is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge clk) begin
    if (commit && op_we && !op_err) begin
      mem[op_addr] <= op_wdata[7:0];
      if (op_size != 2'd0) mem[op_addr + ADDR_BITS'(1)] <= op_wdata[15:8];
      if (op_size == 2'd2) begin
        mem[op_addr + ADDR_BITS'(2)] <= op_wdata[23:16];
        mem[op_addr + ADDR_BITS'(3)] <= op_wdata[31:24];
      end
    end
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: directed load/store cases plus random
// traffic checked against a byte-level reference model.
module tb_data_mem_responder;
  localparam int unsigned WIDTH     = 32;
  localparam int unsigned ADDR_BITS = 17;
  localparam int unsigned LATENCY   = 2;
  localparam int unsigned AddrMask  = (1 << ADDR_BITS) - 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  data_mem_responder_if #(.WIDTH(WIDTH)) bus ();

  data_mem_responder #(
    .WIDTH    (WIDTH),
    .ADDR_BITS(ADDR_BITS),
    .LATENCY  (LATENCY)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  exp_t        exp_q[$];
  logic [7:0]  model_mem[int unsigned];
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %h required %h", name, act, req);
    end
  endtask

  // Reference: access size from funct3, alignment by modulo, bytes kept in a map.
  function automatic void model_access(input logic we, input logic [2:0] mode,
                                       input logic [31:0] addr, input logic [31:0] wdata,
                                       output logic [31:0] rd, output logic err);
    int unsigned a, n;
    logic        sgn, legal;
    logic [31:0] v;
    a = addr & AddrMask;
    n = 1; sgn = 1'b0; legal = 1'b1; rd = '0; v = '0;
    case (mode)
      3'b000:  begin n = 1; sgn = 1'b1; end
      3'b001:  begin n = 2; sgn = 1'b1; end
      3'b010:  n = 4;
      3'b100:  begin n = 1; legal = !we; end
      3'b101:  begin n = 2; legal = !we; end
      default: legal = 1'b0;
    endcase
    err = !legal || (a % n != 0);
    if (err) return;
    if (we) begin
      for (int i = 0; i < int'(n); i++) model_mem[(a + i) & AddrMask] = wdata[8*i +: 8];
    end else begin
      for (int i = 0; i < int'(n); i++) v[8*i +: 8] = model_mem[(a + i) & AddrMask];
      if (sgn && v[8*n-1]) for (int i = 8 * n; i < 32; i++) v[i] = 1'b1;
      rd = v;
    end
  endfunction

  // Response monitor: latency, stability under backpressure, scoreboard pop.
  int          mcyc = 0;
  int          acc_cyc = 0;
  bit          seen = 1'b0;
  bit          ready_next = 1'b0;
  logic [31:0] held_rd;
  logic        held_err;
  exp_t        mon_e;

  always @(negedge clk) begin
    mcyc++;
    if (!rst) begin
      check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("reset_req_ready", 32'(bus.req_ready), 32'd0);
      seen       = 1'b0;
      ready_next = 1'b0;
    end else begin
      if (ready_next) begin
        check("ready_after_handshake", 32'(bus.req_ready), 32'd1);
        ready_next = 1'b0;
      end
      if (bus.req_valid && bus.req_ready) acc_cyc = mcyc;
      if (bus.rsp_valid) begin
        check("busy_req_ready", 32'(bus.req_ready), 32'd0);
        if (!seen) begin
          seen     = 1'b1;
          held_rd  = bus.rsp_rdata;
          held_err = bus.rsp_err;
          check("latency", 32'(mcyc - acc_cyc), 32'(LATENCY + 1));
        end else begin
          check("hold_rdata", bus.rsp_rdata, held_rd);
          check("hold_err", 32'(bus.rsp_err), 32'(held_err));
        end
        if (bus.rsp_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp: actual response rdata %h required none",
                     bus.rsp_rdata);
          end else begin
            mon_e = exp_q.pop_front();
            check("rdata", bus.rsp_rdata, mon_e.rdata);
            check("err", 32'(bus.rsp_err), 32'(mon_e.err));
          end
          seen       = 1'b0;
          ready_next = 1'b1;
        end
      end
    end
  end

  // kind 0: model expectation; 1: literal expectation, model updated;
  // 2: literal expectation, model untouched (request will be aborted).
  task automatic issue(input logic we, input logic [2:0] mode, input logic [31:0] addr,
                       input logic [31:0] wdata, input int kind,
                       input logic [31:0] xr, input logic xe);
    exp_t        e;
    logic [31:0] drd;
    logic        derr;
    bit          ok;
    if (kind == 0) begin
      model_access(we, mode, addr, wdata, e.rdata, e.err);
    end else begin
      if (kind == 1) model_access(we, mode, addr, wdata, drd, derr);
      e.rdata = xr;
      e.err   = xe;
    end
    exp_q.push_back(e);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_mode  = mode;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (bus.req_ready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: actual req_ready low for 50 cycles required high");
      exp_q.delete();
    end
    // Scramble the request lines; the responder must work from its latched copy.
    bus.req_valid = 1'b0;
    bus.req_we    = 1'($urandom);
    bus.req_mode  = 3'($urandom);
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL rsp_timeout: actual %0d responses pending required 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic txn(input logic we, input logic [2:0] mode, input logic [31:0] addr,
                     input logic [31:0] wdata, input int kind,
                     input logic [31:0] xr, input logic xe);
    issue(we, mode, addr, wdata, kind, xr, xe);
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual simulation still running required finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          n;
    logic [31:0] addr;
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_mode  = 3'b000;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b1;
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rdata", bus.rsp_rdata, 32'd0);
    check("reset_err", 32'(bus.rsp_err), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Word store/load and sub-word extension
    txn(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 1, 32'h0, 1'b0);
    txn(1'b0, 3'b010, 32'h100, 32'h0, 1, 32'hDEADBEEF, 1'b0);
    txn(1'b0, 3'b000, 32'h103, 32'h0, 1, 32'hFFFFFFDE, 1'b0);
    txn(1'b0, 3'b100, 32'h103, 32'h0, 1, 32'h000000DE, 1'b0);
    txn(1'b0, 3'b001, 32'h100, 32'h0, 1, 32'hFFFFBEEF, 1'b0);
    txn(1'b0, 3'b101, 32'h102, 32'h0, 1, 32'h0000DEAD, 1'b0);
    // Byte store keeps neighbours
    txn(1'b1, 3'b000, 32'h101, 32'h12345677, 1, 32'h0, 1'b0);
    txn(1'b0, 3'b010, 32'h100, 32'h0, 1, 32'hDEAD77EF, 1'b0);
    // Misalignment and illegal modes
    txn(1'b0, 3'b010, 32'h102, 32'h0, 1, 32'h0, 1'b1);
    txn(1'b1, 3'b001, 32'h101, 32'hAAAA5555, 1, 32'h0, 1'b1);
    txn(1'b0, 3'b010, 32'h100, 32'h0, 1, 32'hDEAD77EF, 1'b0);
    txn(1'b0, 3'b011, 32'h100, 32'h0, 1, 32'h0, 1'b1);
    txn(1'b1, 3'b100, 32'h100, 32'h0, 1, 32'h0, 1'b1);

    // Backpressure with a stray request that must be ignored
    bus.rsp_ready = 1'b0;
    issue(1'b0, 3'b010, 32'h100, 32'h0, 1, 32'hDEAD77EF, 1'b0);
    n = 0;
    while (!bus.rsp_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_mode  = 3'b010;
    bus.req_addr  = 32'h104;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    check("bp_still_valid", 32'(bus.rsp_valid), 32'd1);
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    wait_idle();

    // Reset during WAIT drops an uncommitted store
    txn(1'b1, 3'b010, 32'h200, 32'hCAFEF00D, 1, 32'h0, 1'b0);
    issue(1'b1, 3'b010, 32'h200, 32'h00000055, 2, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("abort_req_ready", 32'(bus.req_ready), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    txn(1'b0, 3'b010, 32'h200, 32'h0, 1, 32'hCAFEF00D, 1'b0);
    // Upper address bits are ignored
    txn(1'b0, 3'b010, 32'h100 | (32'd1 << ADDR_BITS), 32'h0, 1, 32'hDEAD77EF, 1'b0);

    // Random traffic in a prefilled window, sometimes with upper address bits set
    for (int w = 0; w < 16; w++) txn(1'b1, 3'b010, 32'h400 + 32'(4 * w), $urandom, 0, 32'h0, 1'b0);
    for (int k = 0; k < 80; k++) begin
      addr = 32'h400 + 32'($urandom_range(0, 63));
      if ($urandom_range(0, 3) == 0) addr = addr | ($urandom << ADDR_BITS);
      txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), addr, $urandom, 0, 32'h0, 1'b0);
    end

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
